audio_word_serializer: RTL
==========================

# audio_word_serializer

Parametrised parallel-to-serial converter for the audio output path. It takes WIDTH-bit sample words from the address/memory side through a valid/ready handshake and double-buffers them in a one-word holding register. It shifts each word out one bit per DIV clocks on `audio_data`, and drives `audio_enable` for the audio pin (D12). It replaces the fixed 16-bit serializer and adds these features:

- configurable width, bit rate and bit order
- gap-free back-to-back streaming
- a per-word `done` pulse
- underrun detection

## Interface
- WIDTH, 16: bits per sample word; must be ≥ 2.
- DIV, 1: clock cycles per output bit; must be ≥ 1.
- MSB_FIRST, 1: 1 = bit WIDTH-1 first; 0 = bit 0 first.
- IDLE_BIT, 0: level driven on `audio_data` when not shifting.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request; while low, no new word is started.
- data_in  in  WIDTH  sample word.
- data_valid  in  1  `data_in` is valid.
- data_ready  out  1  holding register is empty; equals `~hold_full` (combinational from a flop).
- done  out  1  one-cycle pulse per completed word.
- audio_enable  out  1  high while a word is being shifted.
- audio_data  out  1  serial bit, registered.
- underrun  out  1  one-cycle pulse when the stream starves.
- underrun_count  out  16  only with SER_UNDERRUN_CNT_EN.

## Operation
**Holding register.**
- A word is accepted on an edge where `data_valid && data_ready`: `hold <= data_in`, `hold_full <= 1`.
- `hold_full` clears on the edge where the shifter loads from it.
- Nothing is accepted in the same cycle as a transfer.

**FSM, IDLE → SHIFT (word start).**
- In IDLE: `audio_enable = 0`, `audio_data = IDLE_BIT`.
- On an edge with `enable && hold_full`: load the shifter, clear `hold_full`, `bit_cnt <= 0`, `div_cnt <= 0`, enter SHIFT.
- `audio_data` takes the first bit on that same edge.

**Bit tick in SHIFT.**
- `div_cnt` counts 0..DIV-1.
- A tick occurs when `div_cnt == DIV-1`.
- On a tick with `bit_cnt < WIDTH-1`: shift by one in the configured order and increment `bit_cnt`.

**Last-bit tick (`bit_cnt == WIDTH-1`).** `done <= 1` for one cycle, then exactly one of:
- `enable && hold_full`: reload from hold and stay in SHIFT, with no idle cycle.
- `enable && !hold_full`: `underrun <= 1` for one cycle, go to IDLE.
- `!enable`: go to IDLE, no underrun.

**Boundary conditions.**
- `enable` dropped mid-word: the current word completes normally; there is no truncation.
- `enable` is ignored in IDLE while `hold_full = 0`.
- A word sitting in hold while `enable = 0` is retained until `enable` rises.
- Counters wrap naturally (`bit_cnt` returns to 0 at each load); there is no other wrap.

## Timing
**Reset values** (asynchronous assertion; everything returns immediately):
- `audio_data = IDLE_BIT`, `audio_enable = 0`, `done = 0`, `underrun = 0`, `data_ready = 1`, `underrun_count = 0`.
- State = IDLE.
- Reset mid-word discards both the shifter and the hold register.

**Latency and rate.**
- Word accepted at edge N → `hold_full` at N → load and first bit visible after edge N+1.
- Each bit is held exactly DIV cycles.
- A word occupies WIDTH·DIV cycles.
- `done` is high during the first cycle after the final bit period, i.e. the cycle the next word's first bit appears or IDLE begins.

**Refill window and continuity.**
- For gap-free streaming, the next word must be accepted before the last-bit tick; the producer has WIDTH·DIV−1 cycles after each load.
- `audio_enable` stays high across back-to-back words.

## Configuration
- `SER_UNDERRUN_CNT_EN` defined: adds the `underrun_count` port.
  - 16-bit counter, reset to 0.
  - Increments on each `underrun` pulse.
  - Saturates at 16'hFFFF.
- `SER_UNDERRUN_CNT_EN` not defined: the port and counter are absent; the `underrun` pulse is still present.

## Test plan
1. Single word (WIDTH=16, DIV=1, MSB_FIRST=1): 16'hA5C3, `enable` = 1.
   - `audio_data` = 1010 0101 1100 0011 over 16 cycles; `audio_enable` high for exactly those 16 cycles.
   - `done` pulses once, in the cycle after the last bit.
   - `underrun` pulses in the same cycle as `done`.
2. Back-to-back: 16'hFFFF then 16'h0001, the second sent while the first shifts.
   - 32 contiguous bits, `audio_enable` never drops, `done` pulses 16 cycles apart, no `underrun`.
3. DIV=4, MSB_FIRST=0, word 16'h0003.
   - Bits 1,1 then 0s; each bit is held 4 cycles; `done` comes 64 cycles after load.
4. `enable` dropped at bit 5 with a second word already in hold.
   - The first word finishes all 16 bits, `done` pulses, then IDLE with no `underrun`.
   - The held word starts 1 cycle after `enable` is reasserted.
5. Reset asserted at bit 8, with 3 prior underruns and SER_UNDERRUN_CNT_EN defined.
   - Before reset, `underrun_count` = 3.
   - After reset: `audio_data = IDLE_BIT`, `audio_enable = 0`, `data_ready = 1`, `underrun_count = 0`.
   - Nothing is shifted after release until a new word is accepted.

Source files
------------

// File: rtl/audio_word_serializer_if.sv
// audio_word_serializer_if
//   Bundles the word-side handshake and the serial audio outputs of
//   audio_word_serializer so that producer and serializer share one port.
//
//   Handshake: a word moves from producer to serializer on a rising clock
//   edge where data_valid && data_ready are both high.
//     - data_valid and data_in are driven by the producer.
//     - data_ready is high while the one-word holding register is empty.
//     - The producer may hold data_valid high for any number of cycles.
//
//   Signals:
//     enable         producer -> serializer  run request
//     data_in        producer -> serializer  sample word (WIDTH bits)
//     data_valid     producer -> serializer  data_in is valid
//     data_ready     serializer -> producer  holding register is empty
//     done           serializer -> producer  one-cycle pulse per finished word
//     audio_enable   serializer -> pin       high while a word is shifting
//     audio_data     serializer -> pin       registered serial bit
//     underrun       serializer -> producer  one-cycle pulse on starvation
//     underrun_count serializer -> producer  saturating 16-bit count
//                                            (only with SER_UNDERRUN_CNT_EN)
//
//   Optional feature macro: SER_UNDERRUN_CNT_EN
interface audio_word_serializer_if #(
   parameter int WIDTH = 16
);
   logic             enable;
   logic [WIDTH-1:0] data_in;
   logic             data_valid;
   logic             data_ready;
   logic             done;
   logic             audio_enable;
   logic             audio_data;
   logic             underrun;
`ifdef SER_UNDERRUN_CNT_EN
   logic [15:0]      underrun_count;
`endif

   // Serializer side.
   modport slave (
      input  enable,
      input  data_in,
      input  data_valid,
      output data_ready,
      output done,
      output audio_enable,
      output audio_data,
      output underrun
`ifdef SER_UNDERRUN_CNT_EN
      ,
      output underrun_count
`endif
   );

   // Producer / observer side.
   modport master (
      output enable,
      output data_in,
      output data_valid,
      input  data_ready,
      input  done,
      input  audio_enable,
      input  audio_data,
      input  underrun
`ifdef SER_UNDERRUN_CNT_EN
      ,
      input  underrun_count
`endif
   );
endinterface

// File: rtl/audio_word_serializer.sv
// audio_word_serializer
//   Parallel-to-serial converter for the audio output path. Words arrive over
//   the valid/ready handshake of audio_word_serializer_if into a one-word
//   holding register, then are shifted out one bit every DIV clocks on
//   audio_data while audio_enable is high. A word waiting in hold at the
//   last-bit tick is loaded on that same edge, so back-to-back words stream
//   with no idle cycle.
//
//   Parameters:
//     WIDTH     bits per word (>= 2); must match the interface WIDTH
//     DIV       clock cycles per output bit (>= 1)
//     MSB_FIRST 1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//     IDLE_BIT  level on audio_data while not shifting
//
//   Ports:
//     clock      system clock, rising edge
//     reset      asynchronous, active-high reset
//     bus        audio_word_serializer_if.slave (handshake + audio outputs)
//     state_dbg  1 while the FSM is in SHIFT, 0 in IDLE
//
//   Optional feature macro: SER_UNDERRUN_CNT_EN adds a saturating 16-bit
//   underrun counter on bus.underrun_count.
module audio_word_serializer #(
   parameter int WIDTH     = 16,
   parameter int DIV       = 1,
   parameter int MSB_FIRST = 1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic                   clock,
   input  logic                   reset,
   audio_word_serializer_if.slave bus,
   output logic                   state_dbg
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BIT_W = $clog2(WIDTH);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] hold;
   logic             hold_full;
   logic [WIDTH-1:0] shreg;
   logic [DIV_W-1:0] div_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic             audio_en_r;
   logic             done_r;
   logic             underrun_r;
`ifdef SER_UNDERRUN_CNT_EN
   logic [15:0]      underrun_cnt;
`endif

   logic             accept;
   logic             tick;
   logic             last_bit;
   logic [WIDTH-1:0] shreg_next;

   // hold_full gates data_ready, so a word can never be accepted on the same
   // edge the shifter empties the holding register.
   assign accept   = bus.data_valid && !hold_full;
   assign tick     = (div_cnt == DIV_LAST);
   assign last_bit = (bit_cnt == BIT_LAST);

   // The output end of shreg is audio_data itself, so the pin comes straight
   // from a flop; the shifter is refilled with IDLE_BIT whenever it goes idle.
   assign shreg_next = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg[WIDTH-1:1]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         hold         <= '0;
         hold_full    <= 1'b0;
         shreg        <= {WIDTH{IDLE_BIT}};
         div_cnt      <= '0;
         bit_cnt      <= '0;
         audio_en_r   <= 1'b0;
         done_r       <= 1'b0;
         underrun_r   <= 1'b0;
`ifdef SER_UNDERRUN_CNT_EN
         underrun_cnt <= '0;
`endif
      end else begin
         done_r     <= 1'b0;
         underrun_r <= 1'b0;

         if (accept) begin
            hold      <= bus.data_in;
            hold_full <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (bus.enable && hold_full) begin
                  shreg      <= hold;
                  hold_full  <= 1'b0;
                  bit_cnt    <= '0;
                  div_cnt    <= '0;
                  audio_en_r <= 1'b1;
                  state      <= SHIFT;
               end
            end

            SHIFT: begin
               if (!tick) begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end else begin
                  div_cnt <= '0;
                  if (!last_bit) begin
                     shreg   <= shreg_next;
                     bit_cnt <= bit_cnt + BIT_W'(1);
                  end else begin
                     done_r <= 1'b1;
                     if (bus.enable && hold_full) begin
                        // Reload on the last-bit tick: no idle cycle.
                        shreg     <= hold;
                        hold_full <= 1'b0;
                        bit_cnt   <= '0;
                     end else begin
                        shreg      <= {WIDTH{IDLE_BIT}};
                        audio_en_r <= 1'b0;
                        state      <= IDLE;
                        // Starvation only counts while the stream is wanted.
                        if (bus.enable) begin
                           underrun_r <= 1'b1;
`ifdef SER_UNDERRUN_CNT_EN
                           if (underrun_cnt != 16'hFFFF) begin
                              underrun_cnt <= underrun_cnt + 16'd1;
                           end
`endif
                        end
                     end
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.data_ready   = ~hold_full;
   assign bus.done         = done_r;
   assign bus.audio_enable = audio_en_r;
   assign bus.audio_data   = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
   assign bus.underrun     = underrun_r;
`ifdef SER_UNDERRUN_CNT_EN
   assign bus.underrun_count = underrun_cnt;
`endif
   assign state_dbg = (state == SHIFT);

endmodule
